// File: rtl/imm_gen_pipe_if.sv
// Fetch-to-execute handshake bundle for imm_gen_pipe: instruction in, decoded immediate out,
// plus the illegal-opcode counter and its clear.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      inst;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  imm;
  logic [3:0]       itype;
  logic             illegal;
  logic [CNT_W-1:0] illegal_cnt;
  logic             cnt_clr;

  modport master (
    output in_valid, inst, out_ready, cnt_clr,
    input  in_ready, out_valid, imm, itype, illegal, illegal_cnt
  );

  modport slave (
    input  in_valid, inst, out_ready, cnt_clr,
    output in_ready, out_valid, imm, itype, illegal, illegal_cnt
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered RV32/RV64 immediate generator: opcode-driven class decode, one-deep valid/ready
// output register, saturating illegal-opcode counter. Define IMM_GEN_ZICSR_EN to decode SYSTEM.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  imm_gen_pipe_if.slave bus
);
  typedef logic [XLEN-1:0] xlen_t;
  localparam bit         RV64   = (XLEN == 64);
  localparam logic [3:0] IT_ILL = 4'd15;

  logic [31:0]      inst;
  logic [6:0]       opc;
  logic [2:0]       f3;
  logic             sh;
  xlen_t            imm_i, imm_s, imm_b, imm_u, imm_j;
  xlen_t            imm_d, imm_q;
  logic [3:0]       itype_d, itype_q;
  logic             ill_d, ill_q;
  logic             vld_d, vld_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             accept;

  assign inst = bus.inst;
  assign opc  = inst[6:0];
  assign f3   = inst[14:12];
  assign sh   = (f3 == 3'b001) || (f3 == 3'b101);

  // Signed casts sign-extend from inst[31] to the full datapath width.
  assign imm_i = xlen_t'($signed(inst[31:20]));
  assign imm_s = xlen_t'($signed({inst[31:25], inst[11:7]}));
  assign imm_b = xlen_t'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign imm_u = xlen_t'($signed({inst[31:12], 12'h000}));
  assign imm_j = xlen_t'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

  always_comb begin
    itype_d = IT_ILL;
    imm_d   = xlen_t'(1);
    case (opc)
      7'b0000011: begin itype_d = 4'd0; imm_d = imm_i; end
      7'b0010011: begin
        itype_d = 4'd1;
        if (!sh)       imm_d = imm_i;
        else if (RV64) imm_d = xlen_t'(inst[25:20]);
        else           imm_d = xlen_t'(inst[24:20]);
      end
      7'b0011011: if (RV64) begin
        itype_d = 4'd1;
        imm_d   = sh ? xlen_t'(inst[24:20]) : imm_i;
      end
      7'b0100011: begin itype_d = 4'd2; imm_d = imm_s; end
      7'b0110011: begin itype_d = 4'd3; imm_d = '0; end
      7'b0111011: if (RV64) begin itype_d = 4'd3; imm_d = '0; end
      7'b0110111: begin itype_d = 4'd4; imm_d = imm_u; end
      7'b0010111: begin itype_d = 4'd5; imm_d = imm_u; end
      7'b1100011: begin itype_d = 4'd6; imm_d = imm_b; end
      7'b1100111: begin itype_d = 4'd7; imm_d = imm_i; end
      7'b1101111: begin itype_d = 4'd8; imm_d = imm_j; end
`ifdef IMM_GEN_ZICSR_EN
      7'b1110011: begin
        itype_d = 4'd9;
        case (f3)
          3'b101, 3'b110, 3'b111: imm_d = xlen_t'(inst[19:15]);
          3'b001, 3'b010, 3'b011: imm_d = '0;
          default:                imm_d = imm_i;
        endcase
      end
`endif
      default: ;
    endcase
  end

  assign ill_d        = (itype_d == IT_ILL);
  assign bus.in_ready = !vld_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    vld_d = vld_q;
    if (accept)             vld_d = 1'b1;
    else if (bus.out_ready) vld_d = 1'b0;
  end

  // Clear wins over a same-cycle increment; counting ignores downstream backpressure.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.cnt_clr)                         cnt_d = '0;
    else if (accept && ill_d && !(&cnt_q))   cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= 1'b0;
      imm_q   <= '0;
      itype_q <= '0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      if (accept) begin
        imm_q   <= imm_d;
        itype_q <= itype_d;
        ill_q   <= ill_d;
      end
    end
  end

  assign bus.out_valid   = vld_q;
  assign bus.imm         = imm_q;
  assign bus.itype       = itype_q;
  assign bus.illegal     = ill_q;
  assign bus.illegal_cnt = cnt_q;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: RV32 (CNT_W=16) and RV64 (CNT_W=2) instances driven in lock-step
// with directed vectors, handshake/counter sequences and a random scoreboard phase.
module tb_imm_gen_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .CNT_W(16)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .CNT_W(2))  b64 ();

  imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  imm_gen_pipe #(.XLEN(64), .CNT_W(2))  dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [31:0] inst;
    logic [3:0]  it32;
    logic [31:0] im32;
    logic [3:0]  it64;
    logic [63:0] im64;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic ordy, input logic clr);
    b32.in_valid = v; b32.inst = i; b32.out_ready = ordy; b32.cnt_clr = clr;
    b64.in_valid = v; b64.inst = i; b64.out_ready = ordy; b64.cnt_clr = clr;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk_out(input string nm, input logic [3:0] it32, input logic [31:0] im32,
                         input logic [3:0] it64, input logic [63:0] im64);
    chk({nm, " v32"},   64'(b32.out_valid), 64'd1);
    chk({nm, " it32"},  64'(b32.itype), 64'(it32));
    chk({nm, " im32"},  64'(b32.imm), 64'(im32));
    chk({nm, " ill32"}, 64'(b32.illegal), 64'(it32 == 4'd15));
    chk({nm, " v64"},   64'(b64.out_valid), 64'd1);
    chk({nm, " it64"},  64'(b64.itype), 64'(it64));
    chk({nm, " im64"},  b64.imm, im64);
    chk({nm, " ill64"}, 64'(b64.illegal), 64'(it64 == 4'd15));
  endtask

  // Reference decode straight from the ISA field layout, using shift arithmetic for sign extension.
  function automatic longint sx(input logic [31:0] v, input int bits);
    longint t;
    t = longint'(v) <<< (64 - bits);
    return t >>> (64 - bits);
  endfunction

  function automatic logic [67:0] ref_dec(input logic [31:0] i, input bit rv64);
    logic [3:0]  it;
    logic [63:0] im;
    int          f3;
    bit          shift;
    f3    = int'(i[14:12]);
    shift = (f3 == 1) || (f3 == 5);
    it = 4'd15; im = 64'd1;
    case (i[6:0])
      7'h03: begin it = 0; im = sx(32'(i[31:20]), 12); end
      7'h13: begin it = 1; im = !shift ? sx(32'(i[31:20]), 12) : rv64 ? 64'(i[25:20]) : 64'(i[24:20]); end
      7'h1B: if (rv64) begin it = 1; im = shift ? 64'(i[24:20]) : sx(32'(i[31:20]), 12); end
      7'h23: begin it = 2; im = sx(32'({i[31:25], i[11:7]}), 12); end
      7'h33: begin it = 3; im = 0; end
      7'h3B: if (rv64) begin it = 3; im = 0; end
      7'h37: begin it = 4; im = sx({i[31:12], 12'h0}, 32); end
      7'h17: begin it = 5; im = sx({i[31:12], 12'h0}, 32); end
      7'h63: begin it = 6; im = sx(32'({i[31], i[7], i[30:25], i[11:8], 1'b0}), 13); end
      7'h67: begin it = 7; im = sx(32'(i[31:20]), 12); end
      7'h6F: begin it = 8; im = sx(32'({i[31], i[19:12], i[20], i[30:21], 1'b0}), 21); end
`ifdef IMM_GEN_ZICSR_EN
      7'h73: begin
        it = 9;
        if (f3 >= 5)                im = 64'(i[19:15]);
        else if (f3 >= 1 && f3 <= 3) im = 0;
        else                         im = sx(32'(i[31:20]), 12);
      end
`endif
      default: ;
    endcase
    return {it, im};
  endfunction

  logic [31:0] qm[$];
  int          c32, c64;
  logic        rv, ro, rc;
  logic [31:0] ri, rr;
  logic [6:0]  ops[12];
  logic [67:0] e32, e64;
  bit          exp_ov, exp_ir;

  initial begin
    ops = '{7'h03, 7'h13, 7'h1B, 7'h23, 7'h33, 7'h3B, 7'h37, 7'h17, 7'h63, 7'h67, 7'h6F, 7'h73};
    vt.push_back('{32'hFFF00093, 1, 32'hFFFFFFFF, 1, 64'hFFFFFFFFFFFFFFFF}); // addi -1
    vt.push_back('{32'h12345037, 4, 32'h12345000, 4, 64'h0000000012345000}); // lui
    vt.push_back('{32'hFFDFF06F, 8, 32'hFFFFFFFC, 8, 64'hFFFFFFFFFFFFFFFC}); // jal -4
    vt.push_back('{32'h01F09093, 1, 32'h0000001F, 1, 64'h000000000000001F}); // slli 31
    vt.push_back('{32'h02009093, 1, 32'h00000000, 1, 64'h0000000000000020}); // slli 32 (rv64 shamt)
    vt.push_back('{32'h0000001B, 15, 32'h00000001, 1, 64'h0});               // addiw 0
    vt.push_back('{32'hFFF0009B, 15, 32'h00000001, 1, 64'hFFFFFFFFFFFFFFFF}); // addiw -1
    vt.push_back('{32'h0200909B, 15, 32'h00000001, 1, 64'h0});               // slliw uses [24:20]
    vt.push_back('{32'h002081BB, 15, 32'h00000001, 3, 64'h0});               // addw
    vt.push_back('{32'hFE112E23, 2, 32'hFFFFFFFC, 2, 64'hFFFFFFFFFFFFFFFC}); // sw -4
    vt.push_back('{32'h00000463, 6, 32'h00000008, 6, 64'h8});                // beq +8
    vt.push_back('{32'hFE000EE3, 6, 32'hFFFFFFFC, 6, 64'hFFFFFFFFFFFFFFFC}); // beq -4
    vt.push_back('{32'h002081B3, 3, 32'h00000000, 3, 64'h0});                // add
    vt.push_back('{32'hFFFFF117, 5, 32'hFFFFF000, 5, 64'hFFFFFFFFFFFFF000}); // auipc
    vt.push_back('{32'h7FF080E7, 7, 32'h000007FF, 7, 64'h7FF});              // jalr
    vt.push_back('{32'h80002083, 0, 32'hFFFFF800, 0, 64'hFFFFFFFFFFFFF800}); // lw -2048
    vt.push_back('{32'h40515093, 1, 32'h00000005, 1, 64'h5});                // srai 5
    vt.push_back('{32'h00000090, 15, 32'h00000001, 15, 64'h1});              // inst[1:0]!=11
    vt.push_back('{32'h00000000, 15, 32'h00000001, 15, 64'h1});              // all zeros
`ifdef IMM_GEN_ZICSR_EN
    vt.push_back('{32'h3002D073, 9, 32'h00000005, 9, 64'h5});                // csrrwi zimm=5
    vt.push_back('{32'h30002073, 9, 32'h00000000, 9, 64'h0});                // csrrs
    vt.push_back('{32'h00100073, 9, 32'h00000001, 9, 64'h1});                // ebreak
`else
    vt.push_back('{32'h3002D073, 15, 32'h00000001, 15, 64'h1});
    vt.push_back('{32'h00100073, 15, 32'h00000001, 15, 64'h1});
`endif

    drive(0, 0, 0, 0);
    smp();
    chk("rst v32", 64'(b32.out_valid), 0);
    chk("rst it32", 64'(b32.itype), 0);
    chk("rst im32", 64'(b32.imm), 0);
    chk("rst ill32", 64'(b32.illegal), 0);
    chk("rst cnt32", 64'(b32.illegal_cnt), 0);
    chk("rst rdy32", 64'(b32.in_ready), 1);
    chk("rst v64", 64'(b64.out_valid), 0);
    chk("rst im64", b64.imm, 0);
    rst_n = 1'b1;

    // Directed decode table, one accept per cycle
    foreach (vt[k]) begin
      drive(1, vt[k].inst, 1, 0);
      cyc(); smp();
      chk_out($sformatf("vec%0d", k), vt[k].it32, vt[k].im32, vt[k].it64, vt[k].im64);
    end
    drive(0, 0, 1, 1);
    cyc(); smp();
    chk("drain v32", 64'(b32.out_valid), 0);
    chk("clr cnt32", 64'(b32.illegal_cnt), 0);
    chk("clr cnt64", 64'(b64.illegal_cnt), 0);

    // Backpressure: addi held three cycles, lui waits without being consumed
    drive(1, 32'hFFF00093, 1, 0);
    cyc();
    drive(1, 32'h12345037, 0, 0);
    for (int h = 0; h < 3; h++) begin
      smp();
      chk($sformatf("bp%0d rdy32", h), 64'(b32.in_ready), 0);
      chk($sformatf("bp%0d rdy64", h), 64'(b64.in_ready), 0);
      chk_out($sformatf("bp%0d", h), 1, 32'hFFFFFFFF, 1, 64'hFFFFFFFFFFFFFFFF);
      cyc();
    end
    drive(1, 32'h12345037, 1, 0);
    smp();
    chk("bp rel rdy32", 64'(b32.in_ready), 1);
    chk_out("bp rel", 1, 32'hFFFFFFFF, 1, 64'hFFFFFFFFFFFFFFFF);
    cyc();
    drive(0, 0, 1, 0);
    smp();
    chk_out("bp lui", 4, 32'h12345000, 4, 64'h12345000);
    cyc(); smp();
    chk("bp nodup v32", 64'(b32.out_valid), 0);
    chk("bp nodup v64", 64'(b64.out_valid), 0);

    // Illegal counting, clear priority, saturation
    drive(1, 0, 1, 0);
    cyc(); smp();
    chk_out("ill1", 15, 1, 15, 1);
    chk("ill1 cnt32", 64'(b32.illegal_cnt), 1);
    chk("ill1 cnt64", 64'(b64.illegal_cnt), 1);
    cyc(); smp();
    chk("ill2 cnt32", 64'(b32.illegal_cnt), 2);
    chk("ill2 cnt64", 64'(b64.illegal_cnt), 2);
    drive(1, 0, 1, 1);
    cyc(); smp();
    chk("ill3 clr cnt32", 64'(b32.illegal_cnt), 0);
    chk("ill3 clr cnt64", 64'(b64.illegal_cnt), 0);
    chk_out("ill3", 15, 1, 15, 1);
    drive(1, 0, 1, 0);
    repeat (5) cyc();
    smp();
    chk("sat cnt32", 64'(b32.illegal_cnt), 5);
    chk("sat cnt64", 64'(b64.illegal_cnt), 3);

    // Held illegal instruction is counted once
    drive(0, 0, 1, 1);
    cyc();
    drive(1, 0, 0, 0);
    repeat (4) cyc();
    smp();
    chk("hold rdy32", 64'(b32.in_ready), 0);
    chk("hold cnt32", 64'(b32.illegal_cnt), 1);
    chk("hold cnt64", 64'(b64.illegal_cnt), 1);
    drive(0, 0, 1, 0);
    cyc(); smp();
    chk("hold end cnt32", 64'(b32.illegal_cnt), 1);
    chk("hold end v32", 64'(b32.out_valid), 0);

    // Asynchronous reset with an output in flight
    drive(1, 0, 1, 0);
    cyc();
    drive(0, 0, 0, 0);
    smp();
    chk("pre-rst v32", 64'(b32.out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst v32", 64'(b32.out_valid), 0);
    chk("arst v64", 64'(b64.out_valid), 0);
    chk("arst cnt32", 64'(b32.illegal_cnt), 0);
    chk("arst cnt64", 64'(b64.illegal_cnt), 0);
    #1 rst_n = 1'b1;
    cyc(); smp();
    chk("post-rst v32", 64'(b32.out_valid), 0);

    // Random traffic against a one-entry scoreboard
    c32 = 0; c64 = 0;
    cyc();
    for (int n = 0; n < 400; n++) begin
      rr = $urandom();
      ri = {rr[31:7], ($urandom_range(0, 12) == 12) ? rr[6:0] : ops[$urandom_range(0, 11)]};
      rv = ($urandom_range(0, 3) != 0);
      ro = ($urandom_range(0, 2) != 0);
      rc = ($urandom_range(0, 15) == 0);
      drive(rv, ri, ro, rc);
      smp();
      exp_ov = (qm.size() != 0);
      exp_ir = !exp_ov || ro;
      chk("rnd rdy32", 64'(b32.in_ready), 64'(exp_ir));
      chk("rnd rdy64", 64'(b64.in_ready), 64'(exp_ir));
      chk("rnd v32", 64'(b32.out_valid), 64'(exp_ov));
      chk("rnd v64", 64'(b64.out_valid), 64'(exp_ov));
      chk("rnd cnt32", 64'(b32.illegal_cnt), 64'(c32));
      chk("rnd cnt64", 64'(b64.illegal_cnt), 64'(c64));
      if (exp_ov) begin
        e32 = ref_dec(qm[0], 1'b0);
        e64 = ref_dec(qm[0], 1'b1);
        chk("rnd it32", 64'(b32.itype), 64'(e32[67:64]));
        chk("rnd im32", 64'(b32.imm), 64'(e32[31:0]));
        chk("rnd it64", 64'(b64.itype), 64'(e64[67:64]));
        chk("rnd im64", b64.imm, e64[63:0]);
      end
      if (exp_ov && ro) void'(qm.pop_front());
      if (rc) begin
        c32 = 0; c64 = 0;
      end else if (rv && exp_ir) begin
        e32 = ref_dec(ri, 1'b0);
        e64 = ref_dec(ri, 1'b1);
        if (e32[67:64] == 4'd15 && c32 < 65535) c32++;
        if (e64[67:64] == 4'd15 && c64 < 3) c64++;
      end
      if (rv && exp_ir) qm.push_back(ri);
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, registered successor to the combinational immediate generator.
- Decodes the instruction class directly from the opcode, so no control word is needed.
- Supports XLEN 32 or 64, with shift-amount immediates and RV64 word-op classes.
- Sits between fetch and execute behind a one-deep valid/ready output register, and keeps a saturating count of illegal opcodes.

Parameters:
- XLEN, 32, datapath width; only 32 and 64 are legal.
- CNT_W, 16, width of the illegal-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  inst is presented.
- in_ready  output  1  stage can accept inst this cycle.
- inst  input  32  raw instruction word.
- out_valid  output  1  imm/itype/illegal are valid.
- out_ready  input  1  downstream consumes the output this cycle.
- imm  output  XLEN  sign- or zero-extended immediate.
- itype  output  4  instruction class code.
- illegal  output  1  opcode is not recognised.
- illegal_cnt  output  CNT_W  saturating count of accepted illegal instructions.
- cnt_clr  input  1  synchronous clear of illegal_cnt.

Behaviour:
- Reset (asynchronous, rst_n=0): out_valid=0, imm=0, itype=0, illegal=0, illegal_cnt=0. An in-flight instruction is discarded.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept occurs when in_valid && in_ready; the output registers load on that edge. Latency is 1 cycle.
  - out_valid is set on accept. It clears when out_ready && !accept.
  - While out_valid && !out_ready, all outputs are held stable.
  - Accept and consume in the same cycle gives back-to-back throughput of 1 instruction per cycle.
- itype codes: load 0, op-imm 1, store 2, op 3, lui 4, auipc 5, branch 6, jalr 7, jal 8, csr 9, illegal 15.
- Opcode mapping (inst[6:0]):
  - 0000011→0, 0010011→1, 0100011→2, 0110011→3, 0110111→4, 0010111→5, 1100011→6, 1100111→7, 1101111→8.
  - XLEN=64 only: 0011011 (op-imm-32)→1 and 0111011 (op-32)→3. With XLEN=32 these are illegal.
  - inst[1:0]!=2'b11 → illegal.
- Immediates (sign extension is from inst[31] to XLEN):
  - U (4, 5): inst[31:12] followed by 12 zeros, then sign-extended.
  - J (8): {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - B (6): {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - S (2): {inst[31:25], inst[11:7]}.
  - I (0, 7, and op-imm other than shifts): inst[31:20].
  - op-imm shifts (funct3 001 or 101): imm = zero-extended shamt. Use inst[24:20] for XLEN=32 or op-imm-32; use inst[25:20] for XLEN=64 op-imm.
  - op (3): imm=0.
  - illegal: imm=1, illegal=1, itype=15.
- illegal_cnt:
  - Increments by 1 on each accepted illegal instruction and saturates at all-ones.
  - cnt_clr has priority over an increment in the same cycle; the result is 0.
  - Counting does not depend on out_ready.
- Holding in_valid with in_ready=0 has no side effects, and a held instruction is counted exactly once.

Optional Feature:
- Macro IMM_GEN_ZICSR_EN.
- Defined: opcode 1110011 with funct3 in {101, 110, 111} gives itype 9 and imm = zero-extended zimm inst[19:15]. funct3 in {001, 010, 011} gives itype 9 and imm=0. Any other funct3 (ecall/ebreak) gives itype 9 and imm = sign-extended inst[31:20].
- Not defined: opcode 1110011 is illegal (itype 15, imm=1, counted).

Test Plan:
- XLEN=32, addi 0xFFF00093, out_ready=1 → next cycle out_valid=1, itype=1, imm=0xFFFFFFFF. lui 0x12345037 on the following cycle → itype=4, imm=0x12345000.
- jal 0xFFDFF06F → itype=8, imm=0xFFFFFFFC (XLEN=64: 0xFFFFFFFFFFFFFFFC). slli 0x01F09093 → itype=1, imm=0x1F.
- Backpressure: accept addi, hold out_ready=0 for 3 cycles → in_ready=0, outputs stable, a second inst is not consumed. Raising out_ready gives the second result on the next cycle with no loss or duplication.
- Illegal 0x00000000 presented twice, then cnt_clr with a third illegal in the same cycle → illegal=1, imm=1, itype=15, illegal_cnt goes 1, 2, then 0. CNT_W=2 with 5 illegals → saturates at 3.
- XLEN=32 with 0x0000001B → illegal. XLEN=64 with addiw 0xFFF0009B → itype=1, imm=all ones.
- csrrwi 0x3002D073: with IMM_GEN_ZICSR_EN → itype=9, imm=5; without → illegal. rst_n pulsed low while out_valid=1 → out_valid=0 and illegal_cnt=0 immediately.
